// File: rtl/xsim_dma_pkg.sv
// Shared types for the simulated-DMA round-robin arbiter.
package xsim_dma_pkg;
  localparam int DEF_NUM_CLIENTS = 4;
  localparam int DEF_IDX_W       = $clog2(DEF_NUM_CLIENTS);

  typedef logic [DEF_IDX_W-1:0] client_idx_t;

  typedef struct packed {
    logic        write;
    logic [31:0] handle;
    logic [31:0] addr;
    logic [31:0] data;
  } dma_req_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/xsim_dma_arbiter_rr_pick.sv
// Round-robin find-first: first set bit of elig at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     elig,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);
  int j;

  // Scan from the far end so the last hit written is the nearest to ptr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (elig[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/xsim_dma_arbiter.sv
// Shares one simulated-DMA read slot and write32 path among NUM_CLIENTS requesters.
module xsim_dma_arbiter
  import xsim_dma_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CLIENTS-1:0]   req_valid,
  output logic [NUM_CLIENTS-1:0]   req_ready,
  input  logic [NUM_CLIENTS-1:0]   req_write,
  input  logic [NUM_CLIENTS*32-1:0] req_handle,
  input  logic [NUM_CLIENTS*32-1:0] req_addr,
  input  logic [NUM_CLIENTS*32-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]   rsp_valid,
  input  logic [NUM_CLIENTS-1:0]   rsp_ready,
  output logic [31:0]              rsp_data,
  input  logic                     dma_rdy_readrequest,
  output logic                     dma_en_readrequest,
  output logic [31:0]              dma_readrequest_handle,
  output logic [31:0]              dma_readrequest_addr,
  input  logic                     dma_rdy_readresponse,
  output logic                     dma_en_readresponse,
  input  logic [31:0]              dma_readresponse_data,
  output logic                     dma_en_write32,
  output logic [31:0]              dma_write32_handle,
  output logic [31:0]              dma_write32_addr,
  output logic [31:0]              dma_write32_data
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic [NUM_CLIENTS-1:0] elig;
  logic                   gnt_valid;
  logic [IDX_W-1:0]       gnt_idx;
  dma_req_t               sel;
  logic                   busy, pop, can_grant, grant;

  // Writes never block; reads need the downstream request slot.
  always_comb begin
    elig = req_valid & (req_write | {NUM_CLIENTS{dma_rdy_readrequest}});
  end

  rr_pick #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick (
    .ptr       (rr_ptr_q),
    .elig      (elig),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel.write  = req_write[gnt_idx];
    sel.handle = req_handle[int'(gnt_idx)*32 +: 32];
    sel.addr   = req_addr[int'(gnt_idx)*32 +: 32];
    sel.data   = req_data[int'(gnt_idx)*32 +: 32];

    busy      = (state_q == BUSY);
    pop       = !RST && busy && dma_rdy_readresponse && rsp_ready[owner_q];
    can_grant = !RST && (!busy || pop);
    grant     = can_grant && gnt_valid;

    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;

    dma_en_write32         = grant && sel.write;
    dma_write32_handle     = dma_en_write32 ? sel.handle : 32'h0;
    dma_write32_addr       = dma_en_write32 ? sel.addr   : 32'h0;
    dma_write32_data       = dma_en_write32 ? sel.data   : 32'h0;
    dma_en_readrequest     = grant && !sel.write;
    dma_readrequest_handle = dma_en_readrequest ? sel.handle : 32'h0;
    dma_readrequest_addr   = dma_en_readrequest ? sel.addr   : 32'h0;

    dma_en_readresponse = pop;
    rsp_valid           = '0;
    if (!RST && busy) rsp_valid[owner_q] = dma_rdy_readresponse;
    rsp_data = (!RST && busy) ? dma_readresponse_data : 32'h0;

    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (grant)
      rr_ptr_d = (int'(gnt_idx) == NUM_CLIENTS - 1) ? '0 : gnt_idx + 1'b1;
    if (dma_en_readrequest) begin
      state_d = BUSY;
      owner_d = gnt_idx;
    end else if (pop) begin
      state_d = IDLE;
    end
    if (RST) begin
      state_d  = IDLE;
      owner_d  = '0;
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    state_q  <= state_d;
    owner_q  <= owner_d;
    rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: tb/tb_xsim_dma_arbiter.sv
// Randomized and directed bench for xsim_dma_arbiter against a transaction-level model.
module tb_xsim_dma_arbiter;
  localparam int N = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_handle, req_addr, req_data;
  logic [31:0]     rsp_data;
  logic            dma_rdy_readrequest, dma_en_readrequest;
  logic [31:0]     dma_readrequest_handle, dma_readrequest_addr;
  logic            dma_rdy_readresponse, dma_en_readresponse;
  logic [31:0]     dma_readresponse_data;
  logic            dma_en_write32;
  logic [31:0]     dma_write32_handle, dma_write32_addr, dma_write32_data;

  always #5 CLK = ~CLK;

  xsim_dma_arbiter #(.NUM_CLIENTS(N)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_handle(req_handle), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dma_rdy_readrequest(dma_rdy_readrequest), .dma_en_readrequest(dma_en_readrequest),
    .dma_readrequest_handle(dma_readrequest_handle), .dma_readrequest_addr(dma_readrequest_addr),
    .dma_rdy_readresponse(dma_rdy_readresponse), .dma_en_readresponse(dma_en_readresponse),
    .dma_readresponse_data(dma_readresponse_data),
    .dma_en_write32(dma_en_write32), .dma_write32_handle(dma_write32_handle),
    .dma_write32_addr(dma_write32_addr), .dma_write32_data(dma_write32_data)
  );

  int checks = 0, failures = 0;

  // Model: the outstanding read's owner (-1 = none), the next client to favour,
  // and the downstream's queue of read data waiting to be returned.
  int          m_owner = -1, m_ptr = 0, last_g;
  logic [31:0] dq[$];
  logic [31:0] next_rdata;
  logic        rs_hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Evaluate one cycle: inputs are already applied; compare, advance model, move to next cycle.
  task automatic step();
    int g, c;
    bit popm, is_wr;
    logic [N-1:0] e_ready, e_rv;
    logic [31:0] h, a, d;
    dma_rdy_readresponse  = (dq.size() > 0) && !rs_hold;
    dma_readresponse_data = (dq.size() > 0) ? dq[0] : 32'h0;
    #1;
    g = -1; popm = 0; e_rv = '0; e_ready = '0; is_wr = 0; h = 0; a = 0; d = 0;
    if (!RST) begin
      if (m_owner >= 0 && dma_rdy_readresponse) e_rv[m_owner] = 1'b1;
      popm = (m_owner >= 0) && dma_rdy_readresponse && rsp_ready[m_owner];
      if (m_owner < 0 || popm)
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && req_valid[c] && (req_write[c] || dma_rdy_readrequest)) g = c;
        end
    end
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      is_wr = req_write[g];
      h = req_handle[g*32 +: 32]; a = req_addr[g*32 +: 32]; d = req_data[g*32 +: 32];
    end
    chk("req_ready", req_ready, e_ready);
    chk("en_write32", dma_en_write32, g >= 0 && is_wr);
    chk("en_readreq", dma_en_readrequest, g >= 0 && !is_wr);
    chk("en_readrsp", dma_en_readresponse, popm);
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv != 0) chk("rsp_data", rsp_data, dma_readresponse_data);
    chk("wr_fields", {dma_write32_handle, dma_write32_addr, dma_write32_data},
        (g >= 0 && is_wr) ? {h, a, d} : 96'h0);
    chk("rd_fields", {dma_readrequest_handle, dma_readrequest_addr},
        (g >= 0 && !is_wr) ? {h, a} : 64'h0);
    if (RST) begin
      m_owner = -1; m_ptr = 0; dq.delete();
    end else begin
      if (popm) begin void'(dq.pop_front()); m_owner = -1; end
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (!is_wr) begin m_owner = g; dq.push_back(next_rdata); end
      end
    end
    last_g = g;
    next_rdata = $urandom;
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; rsp_ready = '0; rs_hold = 0;
    dma_rdy_readrequest = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_handle[i*32 +: 32] = $urandom; req_addr[i*32 +: 32] = $urandom;
      req_data[i*32 +: 32]   = $urandom;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; idle_inputs(); step(); RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; idle_inputs(); next_rdata = $urandom;
    dma_rdy_readresponse = 0; dma_readresponse_data = 0;
    #1;
    chk("rst_ready", req_ready, '0);
    chk("rst_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b0);
    chk("rst_rsp", {rsp_valid, rsp_data}, '0);
    step(); RST = 1'b0;

    // Single write from client 2.
    idle_inputs(); req_valid = 4'b0100; req_write = 4'b0100;
    req_handle[64 +: 32] = 32'd5; req_addr[64 +: 32] = 32'h10; req_data[64 +: 32] = 32'hDEADBEEF;
    #1; chk("wr_ready", req_ready, 4'b0100);
    chk("wr_fields_tp", {dma_en_write32, dma_write32_handle, dma_write32_addr, dma_write32_data},
        {1'b1, 32'd5, 32'h10, 32'hDEADBEEF});
    step();

    // Single read from client 1 returning 0x1234.
    idle_inputs(); req_valid = 4'b0010; req_addr[32 +: 32] = 32'h20;
    step(); next_rdata = 32'h1234;
    chk("rd_owner", m_owner, 1);
    dq[0] = 32'h1234;
    idle_inputs(); rsp_ready = '1;
    dma_rdy_readresponse = 1'b1; dma_readresponse_data = 32'h1234; #1;
    chk("rd_rsp_valid", rsp_valid, 4'b0010);
    chk("rd_rsp_data", rsp_data, 32'h1234);
    step();

    // Fairness: all clients write for 8 cycles straight out of reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); req_valid = '1; req_write = '1; step();
      chk("fair_gnt", last_g, i % N);
    end

    // Backpressure: client 1 read held for 5 cycles while 0 and 3 want writes.
    do_reset();
    idle_inputs(); req_valid = 4'b0010; step();
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); req_valid = 4'b1001; req_write = 4'b1001; rsp_ready = 4'b1101;
      #1; chk("bp_no_grant", {req_ready, dma_en_readresponse}, '0);
      step();
    end
    idle_inputs(); req_valid = 4'b1001; req_write = 4'b1001; rsp_ready = 4'b0010;
    step(); chk("bp_pop_gnt", last_g, 3);

    // Back-to-back reads from clients 0 and 1.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle_inputs(); req_valid = 4'b0011; rsp_ready = '1; step();
      chk("b2b_gnt", last_g, i % 2);
    end

    // Reset one cycle after a read grant.
    do_reset();
    idle_inputs(); req_valid = 4'b0100; step();
    RST = 1'b1; idle_inputs(); rsp_ready = '1; step(); RST = 1'b0;
    idle_inputs(); req_valid = '1; req_write = '1; rsp_ready = '1; step();
    chk("post_rst_gnt", last_g, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom % 64) == 0;
      req_valid = $urandom; req_write = $urandom; rsp_ready = $urandom;
      dma_rdy_readrequest = ($urandom % 4) != 0;
      rs_hold = ($urandom % 4) == 0;
      for (int i = 0; i < N; i++) begin
        req_handle[i*32 +: 32] = $urandom; req_addr[i*32 +: 32] = $urandom;
        req_data[i*32 +: 32]   = $urandom;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xsim_dma_arbiter.md
# xsim_dma_arbiter

Round-robin arbiter that shares the single simulated-DMA port (one read request/response slot plus a fire-and-forget 32-bit write path) among `NUM_CLIENTS` requesters in the xsim top level. It sits between the portal/DMA client logic and the DPI-backed DMA read/write block. It tracks the single outstanding read and routes its response back to the owning client. The DMA init/initfd ports are not handled here.

## Interface
- `NUM_CLIENTS`, default 4: number of requesters; must be ≥ 2.
- `IDX_W`, default `$clog2(NUM_CLIENTS)`: client index width.
- `CLK` in, 1: clock.
- `RST` in, 1: reset, synchronous, active-high.
- `req_valid` in, `NUM_CLIENTS`: per-client request valid.
- `req_ready` out, `NUM_CLIENTS`: per-client request accepted this cycle (one-hot or zero).
- `req_write` in, `NUM_CLIENTS`: 1 = write32, 0 = read.
- `req_handle` in, `NUM_CLIENTS`×32: memory handle per client.
- `req_addr` in, `NUM_CLIENTS`×32: byte address per client.
- `req_data` in, `NUM_CLIENTS`×32: write data per client.
- `rsp_valid` out, `NUM_CLIENTS`: read data valid to the owner (one-hot or zero).
- `rsp_ready` in, `NUM_CLIENTS`: client consumes the response.
- `rsp_data` out, 32: read data, shared by all clients.
- `dma_rdy_readrequest` in, 1: downstream can take a read.
- `dma_en_readrequest` out, 1: issue a read.
- `dma_readrequest_handle` out, 32: read handle.
- `dma_readrequest_addr` out, 32: read address.
- `dma_rdy_readresponse` in, 1: downstream read data valid.
- `dma_en_readresponse` out, 1: pop the read data.
- `dma_readresponse_data` in, 32: downstream read data.
- `dma_en_write32` out, 1: issue a write.
- `dma_write32_handle` out, 32: write handle.
- `dma_write32_addr` out, 32: write address.
- `dma_write32_data` out, 32: write data.

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - BUSY: one read outstanding; `owner` register holds the client index.
- `can_grant` is high in IDLE, or in BUSY in the cycle the owner's response pops (`dma_en_readresponse`).
- Arbitration:
  - Round-robin starting at `rr_ptr`; pick the first client with `req_valid`.
  - A read candidate is eligible only if `dma_rdy_readrequest` is high. A write candidate is always eligible.
  - Ineligible candidates are skipped in the same scan.
  - On any grant to client i, `rr_ptr <= (i+1) mod NUM_CLIENTS`.
- Grant of a write: `req_ready[i]=1` and `dma_en_write32=1` in the same cycle, with `dma_write32_*` taken from client i. The FSM state is unchanged.
- Grant of a read: `req_ready[i]=1` and `dma_en_readrequest=1` in the same cycle, with `dma_readrequest_*` taken from client i. Then `owner<=i` and the state goes to BUSY.
- BUSY behaviour:
  - `rsp_valid[owner] = dma_rdy_readresponse`.
  - `rsp_data = dma_readresponse_data`.
  - `dma_en_readresponse = dma_rdy_readresponse & rsp_ready[owner]`.
  - On pop with no new read granted: go to IDLE.
  - On pop with a new read granted the same cycle: stay BUSY with the new `owner`.
- No grants are made in BUSY before the pop, so writes are ordered after the outstanding read.
- `rsp_ready` from non-owners is ignored.
- With `can_grant` low, all `req_ready` and both `dma_en_*` issue strobes are 0.
- All `dma_*` address/handle/data outputs are driven 0 when their enable is 0.
- Reset: state IDLE, `rr_ptr=0`, `owner=0`. The downstream block shares `RST`, so a read in flight at reset is dropped and never returned.

## Timing
- Reset values: all outputs 0.
- `req_ready`, `dma_en_*` and `rsp_valid` are combinational from registered state plus the current inputs (`req_valid`, `dma_rdy_*`, `rsp_ready`). No combinational path exists from `rsp_ready` to `req_ready` except through `can_grant` in BUSY.
- Write latency: accepted in cycle T, so `dma_en_write32` is high in T.
- Read latency:
  - Accepted in T.
  - `dma_rdy_readresponse` is high from T+1, so `rsp_valid` is high from T+1.
  - If `rsp_ready` is high at T+1, the pop happens at T+1 and the next read may be granted in T+1.
  - Sustained read throughput is 1 per cycle.
- If RST is asserted in any cycle, all outputs are 0 in that cycle. The first grant is possible in the cycle after RST deasserts.

## Structure
- Package `xsim_dma_pkg`:
  - `client_idx_t`
  - `dma_req_t` struct {write, handle, addr, data}
  - `state_t` enum {IDLE, BUSY}
- Sub-module `rr_pick`: parameterised round-robin find-first from a pointer over an eligibility vector. Outputs `gnt_valid` and `gnt_idx`. Purely combinational.
- The top module holds the FSM, `rr_ptr`, `owner` and the output muxing.

## Test plan
- Single write: client 2 writes handle=5, addr=0x10, data=0xDEADBEEF → same cycle `req_ready=4'b0100`, `dma_en_write32=1`, fields match; state stays IDLE.
- Single read: client 1 reads addr=0x20, downstream returns 0x1234 → `dma_en_readrequest` in T, `rsp_valid=4'b0010` and `rsp_data=0x1234` in T+1, return to IDLE.
- Fairness: all 4 clients hold write requests for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3.
- Backpressure: read owner holds `rsp_ready=0` for 5 cycles while clients 0 and 3 request writes → no grants and `dma_en_readresponse=0` for 5 cycles; on pop, client 3 or 0 is granted per `rr_ptr` in the same cycle.
- Back-to-back reads: clients 0 and 1 continuously read, `rsp_ready` always 1 → one `dma_en_readrequest` per cycle after the first, alternating owners; each response goes only to the correct owner.
- Reset mid-read: assert RST one cycle after a read grant → all outputs 0, no `rsp_valid` ever for that read, and the first grant after reset goes to client 0.
